// File: rtl/hpdcache_cmo_tracker_adapter.sv
// CMO front-end between the CVA6 CMO port and the HPDcache request/response ports.
// Tracks up to MaxOutstanding CMOs; acks drain in order from a {tid, err} FIFO.
module hpdcache_cmo_tracker_adapter #(
    parameter int unsigned AddrWidth      = 56,
    parameter int unsigned TransIdWidth   = 3,
    parameter int unsigned SidWidth       = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          AckOnRsp       = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [SidWidth-1:0]     sid_i,
    input  logic                    cmo_req_valid_i,
    output logic                    cmo_req_ready_o,
    input  logic [3:0]              cmo_req_op_i,
    input  logic [AddrWidth-1:0]    cmo_req_addr_i,
    input  logic [TransIdWidth-1:0] cmo_req_tid_i,
    output logic                    cmo_ack_o,
    output logic [TransIdWidth-1:0] cmo_ack_tid_o,
    output logic                    cmo_ack_err_o,
    output logic                    dcache_req_valid_o,
    input  logic                    dcache_req_ready_i,
    output logic [AddrWidth-1:0]    dcache_req_addr_o,
    output logic [2:0]              dcache_req_size_o,
    output logic [SidWidth-1:0]     dcache_req_sid_o,
    output logic [TransIdWidth-1:0] dcache_req_tid_o,
    output logic                    dcache_req_need_rsp_o,
    input  logic                    dcache_rsp_valid_i,
    input  logic [SidWidth-1:0]     dcache_rsp_sid_i,
    input  logic [TransIdWidth-1:0] dcache_rsp_tid_i
);

    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned EntW = TransIdWidth + 1;

    // CVA6 CMO opcodes the dcache can execute
    localparam logic [3:0] CMO_INVAL      = 4'd2;
    localparam logic [3:0] CMO_PREFETCH_R = 4'd4;
    localparam logic [3:0] CMO_PREFETCH_W = 4'd5;
    localparam logic [3:0] CMO_INVAL_ALL  = 4'd8;

    // HPDcache CMO sub-op codes carried on the size field
    localparam logic [2:0] HPDCACHE_REQ_CMO_PREFETCH    = 3'h1;
    localparam logic [2:0] HPDCACHE_REQ_CMO_INVAL_NLINE = 3'h2;
    localparam logic [2:0] HPDCACHE_REQ_CMO_INVAL_ALL   = 3'h4;

    logic                    r_active;
    logic [CntW-1:0]         r_cnt;
    logic [LvlW-1:0]         r_wptr;
    logic [LvlW-1:0]         r_rptr;
    logic [EntW-1:0]         r_mem [MaxOutstanding];

    logic                    w_supported;
    logic [2:0]              w_size;
    logic [LvlW-1:0]         w_level;
    logic [CntW-1:0]         w_pend;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_rsp_hit;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_push;
    logic [EntW-1:0]         w_push_data;
    logic [EntW-1:0]         w_head;

    // Opcode classification and translation to the dcache CMO sub-op
    always_comb begin
        w_supported = 1'b0;
        w_size      = 3'h0;
        case (cmo_req_op_i)
            CMO_INVAL: begin
                w_supported = 1'b1;
                w_size      = HPDCACHE_REQ_CMO_INVAL_NLINE;
            end
            CMO_PREFETCH_R, CMO_PREFETCH_W: begin
                w_supported = 1'b1;
                w_size      = HPDCACHE_REQ_CMO_PREFETCH;
            end
            CMO_INVAL_ALL: begin
                w_supported = 1'b1;
                w_size      = HPDCACHE_REQ_CMO_INVAL_ALL;
            end
            default: ;
        endcase
    end

    assign w_level   = r_wptr - r_rptr;
    assign w_pend    = r_cnt - CntW'(w_level);
    assign w_full    = (r_cnt == CntW'(MaxOutstanding));
    assign w_empty   = (r_wptr == r_rptr);
    assign w_rsp_hit = AckOnRsp && r_active && dcache_rsp_valid_i
                       && (dcache_rsp_sid_i == sid_i) && (w_pend != '0);

    // Unsupported ops are held off while a response is pushing, keeping one push per cycle
    assign w_ready     = r_active && !w_full
                         && (w_supported ? dcache_req_ready_i : !w_rsp_hit);
    assign w_accept    = cmo_req_valid_i && w_ready;
    assign w_pop       = !w_empty;
    assign w_push      = w_rsp_hit || (w_accept && (!w_supported || !AckOnRsp));
    assign w_push_data = w_rsp_hit ? {dcache_rsp_tid_i, 1'b0} : {cmo_req_tid_i, !w_supported};
    assign w_head      = r_mem[r_rptr[PtrW-1:0]];

    assign cmo_req_ready_o       = w_ready;
    assign dcache_req_valid_o    = r_active && cmo_req_valid_i && w_supported && !w_full;
    assign dcache_req_addr_o     = r_active ? cmo_req_addr_i : '0;
    assign dcache_req_size_o     = r_active ? w_size : 3'h0;
    assign dcache_req_sid_o      = sid_i;
    assign dcache_req_tid_o      = r_active ? cmo_req_tid_i : '0;
    assign dcache_req_need_rsp_o = AckOnRsp;
    assign cmo_ack_o             = !w_empty;
    assign cmo_ack_tid_o         = w_empty ? '0 : w_head[EntW-1:1];
    assign cmo_ack_err_o         = !w_empty && w_head[0];

    // Holds all outputs quiet during reset and the first cycle after it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_active <= 1'b0;
        else       r_active <= 1'b1;
    end

    // Outstanding counter: +1 per accept, -1 per ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + CntW'(1);
        end else if (!w_accept && w_pop) begin
            r_cnt <= r_cnt - CntW'(1);
        end
    end

    // Ack FIFO storage and pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PtrW-1:0]] <= w_push_data;
                r_wptr                  <= r_wptr + LvlW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + LvlW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        w_push |-> (w_level < LvlW'(MaxOutstanding)));

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_cnt <= CntW'(MaxOutstanding));

endmodule
